// File: rtl/dsp48e2_lite.sv
// Behavioural subset of the DSP48E2 slice: W/X/Y/Z operand muxes, 48-bit ALU, optional P register.
// Define DSP48E2_LITE_MULT_EN to build in the signed 27x18 multiplier that X=01 selects.
module dsp48e2_lite #(
  parameter int          PREG = 0,
  parameter logic [47:0] RND  = 48'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic [29:0] a,
  input  logic [17:0] b,
  input  logic [47:0] c,
  input  logic        carryin,
  input  logic [3:0]  alumode,
  input  logic [8:0]  opmode,
  output logic [47:0] p,
  output logic        carryout
);

  typedef enum logic [3:0] {
    ALU_ADD      = 4'b0000,
    ALU_NOTZ_ADD = 4'b0001,
    ALU_NOT_SUM  = 4'b0010,
    ALU_SUB      = 4'b0011,
    ALU_XOR      = 4'b0100,
    ALU_XNOR     = 4'b0101,
    ALU_AND      = 4'b1100,
    ALU_OR       = 4'b1110
  } alu_op_e;

  localparam logic [47:0] ALL_ONES = 48'hFFFF_FFFF_FFFF;

  logic [47:0] p_q;
  logic        co_q;
  logic [47:0] p_fb;
  logic [47:0] m_val;
  logic [47:0] x_mux, y_mux, z_mux, w_mux;
  logic [48:0] sum_all, sum_notz, diff;
  logic [47:0] p_d;
  logic        co_d;

  // Without an output register there is no P to feed back; forcing 0 breaks the loop.
  assign p_fb = (PREG == 1) ? p_q : '0;

`ifdef DSP48E2_LITE_MULT_EN
  logic signed [44:0] m_prod;
  assign m_prod = $signed(a[26:0]) * $signed(b);
  assign m_val  = {{3{m_prod[44]}}, m_prod};
`else
  assign m_val = '0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    x_mux = '0;
    y_mux = '0;
    z_mux = '0;
    w_mux = '0;
    case (opmode[1:0])
      2'b01:   x_mux = m_val;
      2'b10:   x_mux = p_fb;
      2'b11:   x_mux = {a, b};
      default: x_mux = '0;
    endcase
    case (opmode[3:2])
      2'b10:   y_mux = ALL_ONES;
      2'b11:   y_mux = c;
      default: y_mux = '0;
    endcase
    case (opmode[6:4])
      3'b010:  z_mux = p_fb;
      3'b011:  z_mux = c;
      default: z_mux = '0;
    endcase
    case (opmode[8:7])
      2'b01:   w_mux = p_fb;
      2'b10:   w_mux = RND;
      2'b11:   w_mux = c;
      default: w_mux = '0;
    endcase
  end

  // 49-bit sums so bit 48 is the carry out of the 48-bit result.
  assign sum_all  = {1'b0, z_mux} + {1'b0, w_mux} + {1'b0, x_mux} + {1'b0, y_mux}
                  + {48'b0, carryin};
  assign sum_notz = {1'b0, ~z_mux} + {1'b0, w_mux} + {1'b0, x_mux} + {1'b0, y_mux}
                  + {48'b0, carryin};
  assign diff     = {1'b0, z_mux}
                  - ({1'b0, w_mux} + {1'b0, x_mux} + {1'b0, y_mux} + {48'b0, carryin});

  always_comb begin
    p_d  = '0;
    co_d = 1'b0;
    case (alu_op_e'(alumode))
      ALU_ADD:      {co_d, p_d} = sum_all;
      ALU_NOTZ_ADD: {co_d, p_d} = sum_notz;
      ALU_NOT_SUM: begin
        p_d  = ~sum_all[47:0];
        co_d = sum_all[48];
      end
      ALU_SUB:      {co_d, p_d} = diff;
      ALU_XOR:      p_d = x_mux ^ z_mux;
      ALU_XNOR:     p_d = ~(x_mux ^ z_mux);
      ALU_AND:      p_d = x_mux & z_mux;
      ALU_OR:       p_d = x_mux | z_mux;
      default: begin
        p_d  = '0;
        co_d = 1'b0;
      end
    endcase
  end

  // Reset wins over ce; the register is pruned when PREG=0 since nothing observes it.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      p_q  <= '0;
      co_q <= 1'b0;
    end else if (ce) begin
      p_q  <= p_d;
      co_q <= co_d;
    end
  end

  assign p        = (PREG == 1) ? p_q  : p_d;
  assign carryout = (PREG == 1) ? co_q : co_d;

endmodule

// File: tb/tb_dsp48e2_lite.sv
// Scoreboard bench for dsp48e2_lite: a combinational (PREG=0) and a registered (PREG=1) instance
// share stimulus; expected results are queued at drive time and popped by a negedge monitor.
module tb_dsp48e2_lite;

  localparam logic [47:0] RND_C = 48'h0123_4567_89AB;
  localparam bit [63:0]   M48   = 64'h0000_FFFF_FFFF_FFFF;

  typedef struct {
    string       name;
    logic [47:0] p;
    logic        co;
    bit          chk_co;
    int          due;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        ce;
  logic [29:0] a;
  logic [17:0] b;
  logic [47:0] c;
  logic        carryin;
  logic [3:0]  alumode;
  logic [8:0]  opmode;
  logic [47:0] p_comb, p_reg;
  logic        co_comb, co_reg;

  exp_t        q_comb[$];
  exp_t        q_reg[$];
  int          cyc;
  int          tests;
  int          failed;
  logic [47:0] model_p;
  logic        model_co;

  dsp48e2_lite #(.PREG(0), .RND(RND_C)) u_comb (
    .clock(clock), .reset(reset), .ce(ce), .a(a), .b(b), .c(c), .carryin(carryin),
    .alumode(alumode), .opmode(opmode), .p(p_comb), .carryout(co_comb)
  );

  dsp48e2_lite #(.PREG(1), .RND(RND_C)) u_reg (
    .clock(clock), .reset(reset), .ce(ce), .a(a), .b(b), .c(c), .carryin(carryin),
    .alumode(alumode), .opmode(opmode), .p(p_reg), .carryout(co_reg)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  // Reference: operands picked by the mux tables, then plain 64-bit arithmetic.
  function automatic bit [48:0] ref_alu(input bit [47:0] ab, input bit [47:0] cc, input bit cin,
                                        input bit [3:0] am, input bit [8:0] om,
                                        input bit [47:0] pfb);
    bit [63:0] x, y, z, w, s, m;
    m = 64'd0;
`ifdef DSP48E2_LITE_MULT_EN
    begin
      bit [63:0] ma, mb;
      ma = {{37{ab[44]}}, ab[44:18]};
      mb = {{46{ab[17]}}, ab[17:0]};
      m  = (ma * mb) & M48;
    end
`endif
    case (om[1:0])
      2'd0: x = 0;
      2'd1: x = m;
      2'd2: x = {16'd0, pfb};
      default: x = {16'd0, ab};
    endcase
    case (om[3:2])
      2'd2: y = M48;
      2'd3: y = {16'd0, cc};
      default: y = 0;
    endcase
    case (om[6:4])
      3'd2: z = {16'd0, pfb};
      3'd3: z = {16'd0, cc};
      default: z = 0;
    endcase
    case (om[8:7])
      2'd0: w = 0;
      2'd1: w = {16'd0, pfb};
      2'd2: w = {16'd0, RND_C};
      default: w = {16'd0, cc};
    endcase
    case (am)
      4'b0000: begin s = z + w + x + y + cin;              return {s[48], s[47:0]}; end
      4'b0011: begin s = z - (w + x + y + cin);            return {s[48], s[47:0]}; end
      4'b0001: begin s = (~z & M48) + w + x + y + cin;     return {s[48], s[47:0]}; end
      4'b0010: begin s = z + w + x + y + cin; s = {s[63:48], ~s[47:0]}; return {s[48], s[47:0]}; end
      4'b0100: begin s = x ^ z;                            return {1'b0, s[47:0]}; end
      4'b1100: begin s = x & z;                            return {1'b0, s[47:0]}; end
      4'b1110: begin s = x | z;                            return {1'b0, s[47:0]}; end
      4'b0101: begin s = ~(x ^ z);                         return {1'b0, s[47:0]}; end
      default: return 49'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [47:0] got_p, input logic got_co,
                       input logic [47:0] exp_p, input logic exp_co, input bit chk_co);
    tests++;
    if (got_p !== exp_p || (chk_co && got_co !== exp_co)) begin
      failed++;
      $display("FAIL %s: got p=%h co=%b, expected p=%h co=%b", name, got_p, got_co, exp_p, exp_co);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    while (q_comb.size() > 0 && q_comb[0].due <= cyc) begin
      e = q_comb.pop_front();
      check({"comb/", e.name}, p_comb, co_comb, e.p, e.co, e.chk_co);
    end
    while (q_reg.size() > 0 && q_reg[0].due <= cyc) begin
      e = q_reg.pop_front();
      check({"reg/", e.name}, p_reg, co_reg, e.p, e.co, e.chk_co);
    end
  end

  task automatic push(input bit on_reg, input string name, input logic [47:0] ep,
                      input logic eco, input bit chk_co, input int due);
    exp_t e;
    e.name = name; e.p = ep; e.co = eco; e.chk_co = chk_co; e.due = due;
    if (on_reg) q_reg.push_back(e);
    else        q_comb.push_back(e);
  endtask

  // Applies one cycle of stimulus and queues the model's view of both instances.
  task automatic drive(input string name, input logic [47:0] ab, input logic [47:0] cc,
                       input logic cin, input logic [3:0] am, input logic [8:0] om,
                       input logic rst, input logic en);
    bit [48:0] r;
    bit        chk;
    @(posedge clock);
    #1;
    a = ab[47:18]; b = ab[17:0]; c = cc; carryin = cin;
    alumode = am; opmode = om; reset = rst; ce = en;
    chk = (am != 4'b0011);
    r = ref_alu(ab, cc, cin, am, om, 48'd0);
    push(1'b0, name, r[47:0], r[48], chk, cyc);
    r = ref_alu(ab, cc, cin, am, om, model_p);
    if (rst) begin
      model_p = '0; model_co = 1'b0;
    end else if (en) begin
      model_p = r[47:0]; model_co = r[48];
    end
    push(1'b1, name, model_p, model_co, chk, cyc + 1);
  endtask

  localparam logic [8:0] OP_ADD_AB_C = 9'b00_011_00_11;
  localparam logic [8:0] OP_ACC      = 9'b00_010_00_11;
  localparam logic [8:0] OP_MULT     = 9'b00_000_01_01;

  initial begin
    logic [47:0] ab, cc;
    logic [3:0]  am;
    logic [3:0]  alu_list [8];
    logic [29:0] neg3;
    tests = 0; failed = 0; cyc = 0;
    model_p = '0; model_co = 1'b0;
    reset = 1'b1; ce = 1'b1; a = '0; b = '0; c = '0; carryin = 1'b0;
    alumode = 4'b0000; opmode = '0;
    alu_list = '{4'b0000, 4'b0011, 4'b0001, 4'b0010, 4'b0100, 4'b1100, 4'b1110, 4'b0101};

    drive("reset", 48'd0, 48'd0, 1'b0, 4'b0000, OP_ADD_AB_C, 1'b1, 1'b1);
    push(1'b1, "reset_state", 48'd0, 1'b0, 1'b1, cyc + 1);

    drive("add", 48'd5, 48'd7, 1'b0, 4'b0000, OP_ADD_AB_C, 1'b0, 1'b1);
    push(1'b0, "add_12", 48'd12, 1'b0, 1'b1, cyc);
    drive("add_wrap", 48'hFFFF_FFFF_FFFF, 48'd1, 1'b0, 4'b0000, OP_ADD_AB_C, 1'b0, 1'b1);
    push(1'b0, "add_wrap_carry", 48'd0, 1'b1, 1'b1, cyc);
    drive("sub", 48'd3, 48'd10, 1'b0, 4'b0011, OP_ADD_AB_C, 1'b0, 1'b1);
    push(1'b0, "sub_7", 48'd7, 1'b0, 1'b0, cyc);
    drive("sub_neg", 48'd10, 48'd3, 1'b0, 4'b0011, OP_ADD_AB_C, 1'b0, 1'b1);
    push(1'b0, "sub_neg7", 48'hFFFF_FFFF_FFF9, 1'b0, 1'b0, cyc);
    drive("xor", 48'h0FF0, 48'hF0F0, 1'b0, 4'b0100, OP_ADD_AB_C, 1'b0, 1'b1);
    push(1'b0, "xor_ff00", 48'hFF00, 1'b0, 1'b1, cyc);
    drive("undef_alu", 48'h0FF0, 48'hF0F0, 1'b0, 4'b1111, OP_ADD_AB_C, 1'b0, 1'b1);
    push(1'b0, "undef_alu_zero", 48'd0, 1'b0, 1'b1, cyc);
    neg3 = 30'h3FFF_FFFD;
    drive("mult", {neg3, 18'd4}, 48'd0, 1'b0, 4'b0000, OP_MULT, 1'b0, 1'b1);
`ifdef DSP48E2_LITE_MULT_EN
    push(1'b0, "mult_neg12", 48'hFFFF_FFFF_FFF4, 1'b0, 1'b0, cyc);
`else
    push(1'b0, "mult_disabled", 48'd0, 1'b0, 1'b0, cyc);
`endif
    drive("carryin", 48'd1, 48'd1, 1'b1, 4'b0000, OP_ADD_AB_C, 1'b0, 1'b1);
    push(1'b0, "carryin_3", 48'd3, 1'b0, 1'b1, cyc);

    // Accumulator: reset, 4 enabled clocks, 2 held clocks, reset+ce, then restart from 0.
    drive("acc_rst", 48'd2, 48'd0, 1'b0, 4'b0000, OP_ACC, 1'b1, 1'b1);
    push(1'b1, "acc_rst_0", 48'd0, 1'b0, 1'b1, cyc + 1);
    for (int i = 1; i <= 4; i++) begin
      drive("acc", 48'd2, 48'd0, 1'b0, 4'b0000, OP_ACC, 1'b0, 1'b1);
      push(1'b1, $sformatf("acc_step%0d", i), 48'(2 * i), 1'b0, 1'b1, cyc + 1);
    end
    for (int i = 0; i < 2; i++) begin
      drive("acc_hold", 48'd2, 48'd0, 1'b0, 4'b0000, OP_ACC, 1'b0, 1'b0);
      push(1'b1, "acc_hold_8", 48'd8, 1'b0, 1'b1, cyc + 1);
    end
    drive("acc_rst_ce", 48'd2, 48'd0, 1'b0, 4'b0000, OP_ACC, 1'b1, 1'b1);
    push(1'b1, "acc_rst_priority", 48'd0, 1'b0, 1'b1, cyc + 1);
    drive("acc_restart", 48'd2, 48'd0, 1'b0, 4'b0000, OP_ACC, 1'b0, 1'b1);
    push(1'b1, "acc_restart_2", 48'd2, 1'b0, 1'b1, cyc + 1);

    for (int i = 0; i < 400; i++) begin
      ab = {$urandom, $urandom};
      cc = {$urandom, $urandom};
      am = ($urandom_range(0, 9) == 0) ? 4'($urandom) : alu_list[$urandom_range(0, 7)];
      drive("rand", ab, cc, 1'($urandom), am, 9'($urandom),
            1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0));
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    while (q_comb.size() > 0) begin
      tests++; failed++;
      $display("FAIL comb/%s: never compared, expected p=%h", q_comb[0].name, q_comb[0].p);
      void'(q_comb.pop_front());
    end
    while (q_reg.size() > 0) begin
      tests++; failed++;
      $display("FAIL reg/%s: never compared, expected p=%h", q_reg[0].name, q_reg[0].p);
      void'(q_reg.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
